uart_rx_line_framer: RTL

//  Sits directly downstream of uart_rx_autobaud. Consumes its data/data_val byte strobes
//  and buffers the bytes in a FIFO. It groups them into lines terminated by EOL_CHAR and

---
 rtl/uart_pkg.sv | 12 +
 rtl/line_fifo.sv | 71 +++++++
 rtl/uart_rx_line_framer.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FIFO entry payload for the UART RX line framer.
package uart_pkg;

    localparam logic [7:0] EOL_CHAR = 8'h0A;
    localparam logic [7:0] CR_CHAR  = 8'h0D;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } line_entry_t;

endpackage

// File: rtl/line_fifo.sv
// Show-ahead FIFO of line entries; writes at full and reads at empty are ignored.
module line_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  line_entry_t wr_entry_i,
    input  logic        rd_en_i,
    output line_entry_t rd_entry_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    line_entry_t   mem_q [DEPTH];
    logic          do_wr;
    logic          do_rd;

    // Status, qualified handshakes and next pointer/fill values.
    always_comb begin
        full_o   = (fill_q == FW'(DEPTH));
        empty_o  = (fill_q == '0);
        do_wr    = wr_en_i & ~full_o;
        do_rd    = rd_en_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Pointer and fill registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    assign rd_entry_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_line_framer.sv
// Buffers received bytes and releases them line by line (store-and-forward).
module uart_rx_line_framer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned MAX_LINE = 16,
    parameter int unsigned STRIP_CR = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_val,
    output logic [7:0]                   m_data,
    output logic                         m_last,
    output logic                         m_val,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   line_count,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int unsigned LW = (MAX_LINE > 2) ? $clog2(MAX_LINE) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [LW-1:0] line_len_q, line_len_d;
    logic [CW-1:0] line_count_q, line_count_d;
    logic          overrun_q, overrun_d;
    logic          accept;
    logic          wr_en;
    logic          drop;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    line_entry_t   wr_entry;
    line_entry_t   rd_entry;

    line_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_entry_i (wr_entry),
        .rd_en_i    (pop),
        .rd_entry_o (rd_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Input filter, terminator tagging, and line/overrun bookkeeping.
    always_comb begin
        accept        = rx_val & ((STRIP_CR == 0) | (rx_data != CR_CHAR));
        wr_en         = accept & ~fifo_full;
        drop          = accept & fifo_full;
        wr_entry.data = rx_data;
        wr_entry.last = (rx_data == EOL_CHAR) | (line_len_q == LW'(MAX_LINE - 1));
        m_val         = (line_count_q != '0);
        pop           = m_val & m_ready & ~fifo_empty;
        line_len_d    = line_len_q;
        if (wr_en) begin
            line_len_d = wr_entry.last ? '0 : line_len_q + LW'(1);
        end
        case ({wr_en & wr_entry.last, pop & rd_entry.last})
            2'b10:   line_count_d = line_count_q + CW'(1);
            2'b01:   line_count_d = line_count_q - CW'(1);
            default: line_count_d = line_count_q;
        endcase
        overrun_d = drop | (overrun_q & ~overrun_clr);
    end

    // Line length, complete-line count and sticky overrun registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_len_q   <= '0;
            line_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            line_len_q   <= line_len_d;
            line_count_q <= line_count_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_data     = rd_entry.data;
    assign m_last     = rd_entry.last;
    assign line_count = line_count_q;
    assign overrun    = overrun_q;

endmodule
